// File: rtl/cu_pipe_if.sv
// cu_pipe_if: bundle of the decode inputs and pipelined control outputs of
// the RV32I pipelined control unit.
//   slave  modport : used by cu_pipe (consumes op/funct3/funct7/flush_e/zero_e,
//                    drives ID, EX, MEM and WB control outputs)
//   master modport : used by the surrounding datapath / testbench
interface cu_pipe_if #(
    parameter int unsigned ALUCTRL_W = 4
);
    // ID stage inputs
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    // hazard / EX inputs
    logic                 flush_e;
    logic                 zero_e;
    // ID outputs (combinational)
    logic [2:0]           immsrc_d;
    logic                 illegal_d;
    // EX outputs
    logic [ALUCTRL_W-1:0] alucontrol_e;
    logic                 alusrc_e;
    logic                 jalr_e;
    logic                 pcsrc_e;
    logic [1:0]           resultsrc_e;
    // MEM outputs
    logic                 regwrite_m;
    logic                 memwrite_m;
    // WB outputs
    logic                 regwrite_w;
    logic [1:0]           resultsrc_w;

    modport slave (
        input  op, funct3, funct7, flush_e, zero_e,
        output immsrc_d, illegal_d, alucontrol_e, alusrc_e, jalr_e, pcsrc_e,
               resultsrc_e, regwrite_m, memwrite_m, regwrite_w, resultsrc_w
    );

    modport master (
        output op, funct3, funct7, flush_e, zero_e,
        input  immsrc_d, illegal_d, alucontrol_e, alusrc_e, jalr_e, pcsrc_e,
               resultsrc_e, regwrite_m, memwrite_m, regwrite_w, resultsrc_w
    );
endinterface

// File: rtl/cu_pipe.sv
// cu_pipe: pipelined RV32I control unit for a 5-stage core.
// Decodes op/funct3/funct7 in ID and carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers; PC source is resolved in EX.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous reset, active low (clears all pipeline registers)
//   bus   - cu_pipe_if.slave: ID decode inputs, flush_e, zero_e, and the
//           ID/EX/MEM/WB control outputs
module cu_pipe #(
    parameter int unsigned ALUCTRL_W      = 4,
    parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    cu_pipe_if.slave   bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // ID decode
    logic                 w_regw, w_memw, w_br, w_jmp, w_jalr, w_alusrc, w_illegal;
    logic [2:0]           w_immsrc;
    logic [1:0]           w_ressrc, w_aluop;
    logic [3:0]           w_alu4;
    logic [ALUCTRL_W-1:0] w_aluctrl;
    logic                 w_bubble;
    logic                 w_unused_f7;

    // ID/EX
    logic                 r_regw_e, r_memw_e, r_br_e, r_jmp_e, r_jalr_e, r_alusrc_e, r_f3b0_e;
    logic [1:0]           r_ressrc_e;
    logic [ALUCTRL_W-1:0] r_aluctrl_e;
    // EX/MEM
    logic                 r_regw_m, r_memw_m;
    logic [1:0]           r_ressrc_m;
    // MEM/WB
    logic                 r_regw_w;
    logic [1:0]           r_ressrc_w;

    assign w_unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};

    always_comb begin
        w_regw    = 1'b0;
        w_immsrc  = 3'b000;
        w_alusrc  = 1'b0;
        w_memw    = 1'b0;
        w_ressrc  = 2'b00;
        w_br      = 1'b0;
        w_jmp     = 1'b0;
        w_jalr    = 1'b0;
        w_aluop   = 2'b00;
        w_illegal = 1'b0;
        case (bus.op)
            OP_LW:   begin w_regw = 1'b1; w_alusrc = 1'b1; w_ressrc = 2'b01; end
            OP_SW:   begin w_immsrc = 3'b001; w_alusrc = 1'b1; w_memw = 1'b1; end
            OP_R:    begin w_regw = 1'b1; w_aluop = 2'b10; end
            OP_I:    begin w_regw = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b10; end
            OP_BR: begin
                w_immsrc = 3'b010;
                w_br     = 1'b1;
                w_aluop  = 2'b01;
                // only beq/bne are supported
                w_illegal = (bus.funct3[2:1] != 2'b00);
            end
            OP_JAL:  begin w_regw = 1'b1; w_immsrc = 3'b011; w_ressrc = 2'b10; w_jmp = 1'b1; end
            OP_JALR: begin
                w_regw = 1'b1; w_alusrc = 1'b1; w_ressrc = 2'b10; w_jmp = 1'b1; w_jalr = 1'b1;
            end
            OP_LUI:  begin w_regw = 1'b1; w_immsrc = 3'b100; w_ressrc = 2'b11; end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_regw = 1'b0;
            w_memw = 1'b0;
            w_br   = 1'b0;
            w_jmp  = 1'b0;
        end
    end

    always_comb begin
        w_alu4 = 4'd0;
        case (w_aluop)
            2'b00: w_alu4 = 4'd0;
            2'b01: w_alu4 = 4'd1;
            default: begin
                case (bus.funct3)
                    3'b000:  w_alu4 = (bus.op[5] & bus.funct7[5]) ? 4'd1 : 4'd0;
                    3'b001:  w_alu4 = 4'd7;
                    3'b010:  w_alu4 = 4'd5;
                    3'b011:  w_alu4 = 4'd6;
                    3'b100:  w_alu4 = 4'd4;
                    3'b101:  w_alu4 = bus.funct7[5] ? 4'd9 : 4'd8;
                    3'b110:  w_alu4 = 4'd3;
                    default: w_alu4 = 4'd2;
                endcase
            end
        endcase
        w_aluctrl      = '0;
        w_aluctrl[3:0] = w_alu4;
    end

    assign bus.immsrc_d  = w_immsrc;
    assign bus.illegal_d = w_illegal;

    assign w_bubble = bus.flush_e | (ILLEGAL_AS_NOP & w_illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regw_e    <= 1'b0;
            r_memw_e    <= 1'b0;
            r_ressrc_e  <= 2'b00;
            r_br_e      <= 1'b0;
            r_jmp_e     <= 1'b0;
            r_jalr_e    <= 1'b0;
            r_alusrc_e  <= 1'b0;
            r_aluctrl_e <= '0;
            r_f3b0_e    <= 1'b0;
        end else if (w_bubble) begin
            r_regw_e    <= 1'b0;
            r_memw_e    <= 1'b0;
            r_ressrc_e  <= 2'b00;
            r_br_e      <= 1'b0;
            r_jmp_e     <= 1'b0;
            r_jalr_e    <= 1'b0;
            r_alusrc_e  <= 1'b0;
            r_aluctrl_e <= '0;
            r_f3b0_e    <= 1'b0;
        end else begin
            r_regw_e    <= w_regw;
            r_memw_e    <= w_memw;
            r_ressrc_e  <= w_ressrc;
            r_br_e      <= w_br;
            r_jmp_e     <= w_jmp;
            r_jalr_e    <= w_jalr;
            r_alusrc_e  <= w_alusrc;
            r_aluctrl_e <= w_aluctrl;
            r_f3b0_e    <= bus.funct3[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regw_m   <= 1'b0;
            r_memw_m   <= 1'b0;
            r_ressrc_m <= 2'b00;
            r_regw_w   <= 1'b0;
            r_ressrc_w <= 2'b00;
        end else begin
            r_regw_m   <= r_regw_e;
            r_memw_m   <= r_memw_e;
            r_ressrc_m <= r_ressrc_e;
            r_regw_w   <= r_regw_m;
            r_ressrc_w <= r_ressrc_m;
        end
    end

    // funct3[0] distinguishes bne from beq by inverting the zero test
    assign bus.pcsrc_e      = (r_br_e & (bus.zero_e ^ r_f3b0_e)) | r_jmp_e;
    assign bus.alucontrol_e = r_aluctrl_e;
    assign bus.alusrc_e     = r_alusrc_e;
    assign bus.jalr_e       = r_jalr_e;
    assign bus.resultsrc_e  = r_ressrc_e;
    assign bus.regwrite_m   = r_regw_m;
    assign bus.memwrite_m   = r_memw_m;
    assign bus.regwrite_w   = r_regw_w;
    assign bus.resultsrc_w  = r_ressrc_w;
endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: directed self-checking bench for cu_pipe. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_cu_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cu_pipe_if #(.ALUCTRL_W(4)) bus ();

    cu_pipe #(
        .ALUCTRL_W      (4),
        .ILLEGAL_AS_NOP (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        bus.op     = o;
        bus.funct3 = f3;
        bus.funct7 = f7;
    endtask

    task automatic regs_zero(input string tag);
        chk({tag, "_aluctrl"}, 32'(bus.alucontrol_e), 32'd0);
        chk({tag, "_alusrc"},  32'(bus.alusrc_e),     32'd0);
        chk({tag, "_jalr"},    32'(bus.jalr_e),       32'd0);
        chk({tag, "_pcsrc"},   32'(bus.pcsrc_e),      32'd0);
        chk({tag, "_ressrc_e"},32'(bus.resultsrc_e),  32'd0);
        chk({tag, "_regw_m"},  32'(bus.regwrite_m),   32'd0);
        chk({tag, "_memw_m"},  32'(bus.memwrite_m),   32'd0);
        chk({tag, "_regw_w"},  32'(bus.regwrite_w),   32'd0);
        chk({tag, "_ressrc_w"},32'(bus.resultsrc_w),  32'd0);
    endtask

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.flush_e = 1'b0;
        bus.zero_e  = 1'b0;
        instr(LW, 3'b010, 7'd0);

        // reset state, comb decode still live
        @(negedge clk);
        regs_zero("rst");
        chk("rst_immsrc_lw", 32'(bus.immsrc_d), 32'd0);
        chk("rst_illegal_lw", 32'(bus.illegal_d), 32'd0);
        rst_n = 1'b1;                                   // N0: lw in ID

        @(negedge clk);                                 // N1
        chk("lw_alusrc_e", 32'(bus.alusrc_e), 32'd1);
        chk("lw_aluctrl_e", 32'(bus.alucontrol_e), 32'd0);
        chk("lw_ressrc_e", 32'(bus.resultsrc_e), 32'd1);
        chk("lw_pcsrc_e", 32'(bus.pcsrc_e), 32'd0);
        instr(RT, 3'b000, 7'b0100000);                  // sub

        @(negedge clk);                                 // N2
        chk("sub_aluctrl", 32'(bus.alucontrol_e), 32'd1);
        chk("sub_alusrc", 32'(bus.alusrc_e), 32'd0);
        chk("lw_regw_m", 32'(bus.regwrite_m), 32'd1);
        chk("lw_memw_m", 32'(bus.memwrite_m), 32'd0);
        instr(RT, 3'b000, 7'b0000000);                  // add

        @(negedge clk);                                 // N3
        chk("add_aluctrl", 32'(bus.alucontrol_e), 32'd0);
        chk("lw_regw_w", 32'(bus.regwrite_w), 32'd1);
        chk("lw_ressrc_w", 32'(bus.resultsrc_w), 32'd1);
        chk("sub_regw_m", 32'(bus.regwrite_m), 32'd1);
        instr(IT, 3'b101, 7'b0100000);                  // srai

        @(negedge clk);                                 // N4
        chk("srai_aluctrl", 32'(bus.alucontrol_e), 32'd9);
        chk("srai_alusrc", 32'(bus.alusrc_e), 32'd1);
        instr(IT, 3'b100, 7'b0000000);                  // xori

        @(negedge clk);                                 // N5
        chk("xori_aluctrl", 32'(bus.alucontrol_e), 32'd4);
        instr(BR, 3'b001, 7'd0);                        // bne
        bus.zero_e = 1'b0;
        #1;
        chk("bne_immsrc", 32'(bus.immsrc_d), 32'd2);

        @(negedge clk);                                 // N6
        chk("bne_z0_pcsrc", 32'(bus.pcsrc_e), 32'd1);
        chk("bne_aluctrl", 32'(bus.alucontrol_e), 32'd1);
        bus.zero_e = 1'b1;
        #1;
        chk("bne_z1_pcsrc", 32'(bus.pcsrc_e), 32'd0);
        instr(BR, 3'b000, 7'd0);                        // beq

        @(negedge clk);                                 // N7
        chk("beq_z1_pcsrc", 32'(bus.pcsrc_e), 32'd1);
        bus.zero_e = 1'b0;
        #1;
        chk("beq_z0_pcsrc", 32'(bus.pcsrc_e), 32'd0);
        chk("bne_regw_m", 32'(bus.regwrite_m), 32'd0);
        instr(JAL, 3'b000, 7'd0);
        #1;
        chk("jal_immsrc", 32'(bus.immsrc_d), 32'd3);

        @(negedge clk);                                 // N8
        chk("jal_pcsrc", 32'(bus.pcsrc_e), 32'd1);
        chk("jal_ressrc_e", 32'(bus.resultsrc_e), 32'd2);
        chk("jal_jalr_e", 32'(bus.jalr_e), 32'd0);
        instr(SW, 3'b010, 7'd0);
        bus.flush_e = 1'b1;
        #1;
        chk("sw_immsrc", 32'(bus.immsrc_d), 32'd1);

        @(negedge clk);                                 // N9: flushed sw in EX
        chk("flush_aluctrl", 32'(bus.alucontrol_e), 32'd0);
        chk("flush_alusrc", 32'(bus.alusrc_e), 32'd0);
        chk("flush_jalr", 32'(bus.jalr_e), 32'd0);
        chk("flush_pcsrc", 32'(bus.pcsrc_e), 32'd0);
        chk("flush_ressrc_e", 32'(bus.resultsrc_e), 32'd0);
        bus.flush_e = 1'b0;
        instr(JALR, 3'b000, 7'd0);

        @(negedge clk);                                 // N10
        chk("flush_memw_m", 32'(bus.memwrite_m), 32'd0);
        chk("jalr_jalr_e", 32'(bus.jalr_e), 32'd1);
        chk("jalr_pcsrc", 32'(bus.pcsrc_e), 32'd1);
        chk("jalr_alusrc", 32'(bus.alusrc_e), 32'd1);
        chk("jalr_ressrc_e", 32'(bus.resultsrc_e), 32'd2);
        instr(7'b0000000, 3'b000, 7'd0);
        #1;
        chk("op0_illegal", 32'(bus.illegal_d), 32'd1);

        @(negedge clk);                                 // N11
        chk("op0_alusrc_e", 32'(bus.alusrc_e), 32'd0);
        chk("op0_pcsrc_e", 32'(bus.pcsrc_e), 32'd0);
        instr(BR, 3'b100, 7'd0);
        #1;
        chk("br100_illegal", 32'(bus.illegal_d), 32'd1);

        @(negedge clk);                                 // N12
        bus.zero_e = 1'b1;
        #1;
        chk("br100_pcsrc", 32'(bus.pcsrc_e), 32'd0);
        chk("br100_aluctrl", 32'(bus.alucontrol_e), 32'd0);
        bus.zero_e = 1'b0;
        instr(LUI, 3'b000, 7'd0);
        #1;
        chk("lui_immsrc", 32'(bus.immsrc_d), 32'd4);
        chk("lui_illegal", 32'(bus.illegal_d), 32'd0);

        @(negedge clk);                                 // N13
        chk("op0_regw_w", 32'(bus.regwrite_w), 32'd0);
        chk("lui_ressrc_e", 32'(bus.resultsrc_e), 32'd3);
        chk("lui_alusrc_e", 32'(bus.alusrc_e), 32'd0);
        chk("br100_memw_m", 32'(bus.memwrite_m), 32'd0);
        instr(SW, 3'b010, 7'd0);

        @(negedge clk);                                 // N14
        chk("br100_regw_w", 32'(bus.regwrite_w), 32'd0);
        chk("sw_alusrc_e", 32'(bus.alusrc_e), 32'd1);
        chk("sw_pcsrc_e", 32'(bus.pcsrc_e), 32'd0);
        instr(LW, 3'b010, 7'd0);

        @(negedge clk);                                 // N15
        chk("sw_memw_m", 32'(bus.memwrite_m), 32'd1);
        chk("sw_regw_m", 32'(bus.regwrite_m), 32'd0);
        chk("lui_regw_w", 32'(bus.regwrite_w), 32'd1);
        chk("lui_ressrc_w", 32'(bus.resultsrc_w), 32'd3);
        instr(RT, 3'b110, 7'd0);                        // or

        @(negedge clk);                                 // N16
        chk("or_aluctrl", 32'(bus.alucontrol_e), 32'd3);
        chk("pre_rst_regw_m", 32'(bus.regwrite_m), 32'd1);
        chk("pre_rst_ressrc_e", 32'(bus.resultsrc_e), 32'd0);
        instr(SW, 3'b010, 7'd0);

        // asynchronous reset in the middle of the low phase
        #2;
        rst_n = 1'b0;
        #1;
        regs_zero("midrst");
        chk("midrst_immsrc", 32'(bus.immsrc_d), 32'd1);
        instr(LW, 3'b010, 7'd0);

        @(negedge clk);                                 // N17: release
        regs_zero("rst_held");
        rst_n = 1'b1;

        @(negedge clk);                                 // N18
        chk("post_lw_alusrc_e", 32'(bus.alusrc_e), 32'd1);
        chk("post_regw_w_e1", 32'(bus.regwrite_w), 32'd0);
        instr(SW, 3'b010, 7'd0);

        @(negedge clk);                                 // N19
        chk("post_regw_m", 32'(bus.regwrite_m), 32'd1);
        chk("post_regw_w_e2", 32'(bus.regwrite_w), 32'd0);

        @(negedge clk);                                 // N20
        chk("post_regw_w_e3", 32'(bus.regwrite_w), 32'd1);
        chk("post_ressrc_w", 32'(bus.resultsrc_w), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
